// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded operation requests into RV32IMF instruction
// words. It range-checks immediates, tags each word with a sequential byte
// address and buffers {word, address} pairs in a DEPTH-entry FIFO.
//
// Handshakes (both ports): a transfer happens at a rising edge where
// valid && ready are both high. req_rdy depends only on registered FIFO
// occupancy, so it has no combinational path from inst_rdy. A request that
// fails encoding still completes its handshake but is dropped and sets err.
module inst_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [3:0]  req_op,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        inst_vld,
    input  logic        inst_rdy,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        err,
    output logic [15:0] enc_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Request class codes
    localparam logic [3:0] OP_R      = 4'd0;
    localparam logic [3:0] OP_IARITH = 4'd1;
    localparam logic [3:0] OP_ILD    = 4'd2;
    localparam logic [3:0] OP_JALR   = 4'd3;
    localparam logic [3:0] OP_S      = 4'd4;
    localparam logic [3:0] OP_B      = 4'd5;
    localparam logic [3:0] OP_J      = 4'd6;
    localparam logic [3:0] OP_LUI    = 4'd7;
    localparam logic [3:0] OP_AUIPC  = 4'd8;
    localparam logic [3:0] OP_FSW    = 4'd9;
    localparam logic [3:0] OP_FLW    = 4'd10;
    localparam logic [3:0] OP_RFLT   = 4'd11;

    // Major opcodes
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IARITH = 7'b0010011;
    localparam logic [6:0] OPC_ILD    = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_S      = 7'b0100011;
    localparam logic [6:0] OPC_B      = 7'b1100011;
    localparam logic [6:0] OPC_J      = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_RFLT   = 7'b1010011;

    logic [31:0]   mem_word [DEPTH];
    logic [31:0]   mem_addr [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   next_addr;

    logic [31:0] word;
    logic        enc_err;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;
    logic        accept;
    logic        push;
    logic        pop;

    // Immediate range checks: value must sign-extend from the given bit
    assign fits_12 = (req_imm[31:11] == {21{req_imm[11]}});
    assign fits_13 = (req_imm[31:12] == {20{req_imm[12]}});
    assign fits_21 = (req_imm[31:20] == {12{req_imm[20]}});

    assign req_rdy  = (count < CW'(DEPTH));
    assign inst_vld = (count != '0);
    assign inst     = mem_word[rd_ptr];
    assign inst_addr = mem_addr[rd_ptr];

    assign accept = req_vld && req_rdy;
    assign push   = accept && !enc_err;
    assign pop    = inst_vld && inst_rdy;

    // Encode the current request into a word and flag range/class errors
    always_comb begin
        word    = '0;
        enc_err = 1'b0;
        case (req_op)
            OP_R: begin
                word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OPC_R};
            end
            OP_IARITH: begin
                if (req_funct3 == 3'b001 || req_funct3 == 3'b101) begin
                    // Shift-immediates carry funct7 above a 5-bit shamt
                    word    = {req_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, OPC_IARITH};
                    enc_err = |req_imm[31:5];
                end else begin
                    word    = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_IARITH};
                    enc_err = !fits_12;
                end
            end
            OP_ILD: begin
                word    = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_ILD};
                enc_err = !fits_12;
            end
            OP_JALR: begin
                word    = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_JALR};
                enc_err = !fits_12;
            end
            OP_S: begin
                word    = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OPC_S};
                enc_err = !fits_12;
            end
            OP_B: begin
                word    = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                           req_imm[4:1], req_imm[11], OPC_B};
                enc_err = !fits_13 || req_imm[0];
            end
            OP_J: begin
                word    = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OPC_J};
                enc_err = !fits_21 || req_imm[0];
            end
            OP_LUI: begin
                word    = {req_imm[31:12], req_rd, OPC_LUI};
                enc_err = |req_imm[11:0];
            end
            OP_AUIPC: begin
                word    = {req_imm[31:12], req_rd, OPC_AUIPC};
                enc_err = |req_imm[11:0];
            end
            OP_FSW: begin
                word    = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], OPC_FSW};
                enc_err = !fits_12;
            end
            OP_FLW: begin
                word    = {req_imm[11:0], req_rs1, 3'b010, req_rd, OPC_FLW};
                enc_err = !fits_12;
            end
            OP_RFLT: begin
                word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OPC_RFLT};
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
    end

    // FIFO pointers, occupancy, address counter, error flag and word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            next_addr <= BASE_ADDR;
            err       <= 1'b0;
            enc_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + AW'(1);
                next_addr <= next_addr + 32'd4;
                if (enc_cnt != 16'hFFFF) begin
                    enc_cnt <= enc_cnt + 16'd1;
                end
            end
            if (accept && enc_err) begin
                err <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr] <= word;
            mem_addr[wr_ptr] <= next_addr;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed encodings, error handling,
// FIFO full/drain ordering and mid-operation reset.
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic [3:0]  req_op;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        inst_vld;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        err;
  logic [15:0] enc_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  inst_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_op     (req_op),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .inst_vld   (inst_vld),
    .inst_rdy   (inst_rdy),
    .inst       (inst),
    .inst_addr  (inst_addr),
    .err        (err),
    .enc_cnt    (enc_cnt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    req_op     = op;
    req_funct3 = f3;
    req_funct7 = f7;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_imm    = imm;
  endtask

  // Present a request and hold it until accepted (bounded). Called and
  // returns 1 time unit after a rising edge.
  task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    int w;
    set_req(op, f3, f7, rd, rs1, rs2, imm);
    req_vld = 1'b1;
    w = 0;
    while (!req_rdy && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("send_rdy", {31'b0, req_rdy}, 32'd1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
  endtask

  // Wait (bounded) for a head entry, check it, then pop it.
  task automatic pop_check(input string tag, input logic [31:0] exp_word, input logic [31:0] exp_addr);
    int w;
    w = 0;
    while (!inst_vld && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check({tag, "_vld"}, {31'b0, inst_vld}, 32'd1);
    check({tag, "_word"}, inst, exp_word);
    check({tag, "_addr"}, inst_addr, exp_addr);
    inst_rdy = 1'b1;
    @(posedge clk);
    #1;
    inst_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    req_vld  = 1'b0;
    inst_rdy = 1'b0;
    set_req(4'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_vld", {31'b0, inst_vld}, 32'd0);
    check("rst_rdy", {31'b0, req_rdy}, 32'd1);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_cnt", {16'b0, enc_cnt}, 32'd0);

    // ADD x3,x1,x2
    send(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    check("add_vld", {31'b0, inst_vld}, 32'd1);
    check("add_cnt", {16'b0, enc_cnt}, 32'd1);
    pop_check("add", 32'h002081B3, BASE);
    check("add_empty", {31'b0, inst_vld}, 32'd0);

    // ADDI x5,x0,-1 then LUI x1,0x12345 back to back
    send(4'd1, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    send(4'd7, 3'd7, 7'd0, 5'd1, 5'd9, 5'd9, 32'h1234_5000);
    check("b2b_cnt", {16'b0, enc_cnt}, 32'd3);
    pop_check("addi", 32'hFFF00293, BASE + 32'd4);
    pop_check("lui", 32'h123450B7, BASE + 32'd8);

    // BEQ x1,x2,+8 encodes; BEQ with odd offset errors and is dropped
    send(4'd5, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    pop_check("beq", 32'h00208463, BASE + 32'd12);
    send(4'd5, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
    check("beq7_err", {31'b0, err}, 32'd1);
    check("beq7_nopush", {31'b0, inst_vld}, 32'd0);
    check("beq7_cnt", {16'b0, enc_cnt}, 32'd4);
    send(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    pop_check("after_beq7", 32'h002081B3, BASE + 32'd16);
    check("err_sticky", {31'b0, err}, 32'd1);

    // ADDI imm=2048 out of range after a clean reset
    do_reset();
    check("rst2_err", {31'b0, err}, 32'd0);
    send(4'd1, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048);
    check("addi2048_err", {31'b0, err}, 32'd1);
    check("addi2048_cnt", {16'b0, enc_cnt}, 32'd0);
    check("addi2048_rdy", {31'b0, req_rdy}, 32'd1);
    check("addi2048_nopush", {31'b0, inst_vld}, 32'd0);
    send(4'd1, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5);
    pop_check("addi5", 32'h00510093, BASE);
    check("addi5_cnt", {16'b0, enc_cnt}, 32'd1);

    // Full/drain with varied formats: 4 accepted, 5th stalls until a pop
    do_reset();
    send(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);                // ADD
    send(4'd1, 3'b001, 7'b0000000, 5'd1, 5'd2, 5'd0, 32'd3);        // SLLI
    send(4'd1, 3'b101, 7'b0100000, 5'd1, 5'd2, 5'd0, 32'd3);        // SRAI
    send(4'd4, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);              // SW
    check("full_rdy", {31'b0, req_rdy}, 32'd0);
    check("full_cnt", {16'b0, enc_cnt}, 32'd4);
    set_req(4'd6, 3'd5, 7'd0, 5'd1, 5'd7, 5'd7, 32'h0000_0800);     // JAL x1,+2048
    req_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stall_rdy", {31'b0, req_rdy}, 32'd0);
    check("stall_cnt", {16'b0, enc_cnt}, 32'd4);
    pop_check("drain0", 32'h002081B3, BASE);
    check("rdy_rise", {31'b0, req_rdy}, 32'd1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    check("jal_cnt", {16'b0, enc_cnt}, 32'd5);
    pop_check("drain1", 32'h00311093, BASE + 32'd4);
    pop_check("drain2", 32'h40315093, BASE + 32'd8);
    pop_check("drain3", 32'h0020A423, BASE + 32'd12);
    pop_check("drain4", 32'h001000EF, BASE + 32'd16);
    check("drain_empty", {31'b0, inst_vld}, 32'd0);

    // 3 buffered, illegal class sets err, then reset with a request held
    send(4'd10, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd4);               // FLW f1,4(x2)
    send(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(4'd12, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    check("illegal_err", {31'b0, err}, 32'd1);
    check("pre_rst_cnt", {16'b0, enc_cnt}, 32'd8);
    req_vld = 1'b1;
    set_req(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    do_reset();
    req_vld = 1'b0;
    check("rst3_vld", {31'b0, inst_vld}, 32'd0);
    check("rst3_err", {31'b0, err}, 32'd0);
    check("rst3_cnt", {16'b0, enc_cnt}, 32'd0);
    send(4'd10, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd4);
    pop_check("post_rst", 32'h00412087, BASE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
